// File: rtl/uart_baud_pkg.sv
// Shared encodings and defaults for the UART baud-rate generator.
// The fractional divider is built only when UART_BAUD_FRAC_EN is defined.
package uart_baud_pkg;

    localparam int DIV_W_DEF  = 16;
    localparam int FRAC_W_DEF = 4;

    typedef enum logic [1:0] {
        OSR_16   = 2'd0,
        OSR_8    = 2'd1,
        OSR_4    = 2'd2,
        OSR_RSVD = 2'd3
    } osr_sel_e;

    // Reserved encoding falls back to 16x oversampling.
    function automatic logic [4:0] osr_len(input osr_sel_e sel);
        case (sel)
            OSR_8:   osr_len = 5'd8;
            OSR_4:   osr_len = 5'd4;
            default: osr_len = 5'd16;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_prescaler.sv
// Integer/fractional pclk divider producing the one-cycle oversample tick.
// Fractional stretch logic exists only when UART_BAUD_FRAC_EN is defined.
module uart_baud_prescaler
    import uart_baud_pkg::*;
#(
    parameter int DIV_W  = DIV_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [DIV_W-1:0]  i_div,
    input  logic [FRAC_W-1:0] i_frac,
    output logic              o_wrap,
    output logic              o_os_tick
);

    logic [DIV_W:0] r_cnt;
    logic [DIV_W:0] w_lim;
    logic           w_stretch;
    logic           r_os_tick;

`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_W-1:0] r_acc;
    logic              r_stretch;
    logic [FRAC_W:0]   w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, i_frac};

    // The carry lengthens only the period that follows this wrap.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            r_acc     <= '0;
            r_stretch <= 1'b0;
        end else if (o_wrap) begin
            r_acc     <= w_sum[FRAC_W-1:0];
            r_stretch <= w_sum[FRAC_W];
        end
    end

    assign w_stretch = r_stretch;
`else
    logic w_unused_frac;
    assign w_unused_frac = ^i_frac;
    assign w_stretch     = 1'b0;
`endif

    assign w_lim  = {1'b0, i_div} + {{DIV_W{1'b0}}, w_stretch};
    assign o_wrap = i_en && (r_cnt == w_lim);

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            r_cnt     <= '0;
            r_os_tick <= 1'b0;
        end else begin
            r_os_tick <= o_wrap;
            r_cnt     <= o_wrap ? '0 : r_cnt + (DIV_W+1)'(1);
        end
    end

    assign o_os_tick = r_os_tick;

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud generator: shadow config, prescaler, TX and RX oversample counters.
// Define UART_BAUD_FRAC_EN to build the fractional divisor support.
module uart_baud_gen
    import uart_baud_pkg::*;
#(
    parameter int DIV_W  = DIV_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic              brg_en,
    input  logic [DIV_W-1:0]  brg_div,
    input  logic [FRAC_W-1:0] brg_frac,
    input  logic [1:0]        brg_osr,
    input  logic              rx_resync,
    output logic              brg_os_tick,
    output logic              brg_tx_tick,
    output logic              brg_rx_tick,
    output logic              brg_rx_sample
);

    logic [DIV_W-1:0]  r_div;
    logic [FRAC_W-1:0] r_frac;
    osr_sel_e          r_osr;

    // Config is only sampled while the generator is idle.
    always_ff @(posedge pclk) begin
        if (prst) begin
            r_div  <= '0;
            r_frac <= '0;
            r_osr  <= OSR_16;
        end else if (!brg_en) begin
            r_div  <= brg_div;
            r_frac <= brg_frac;
            r_osr  <= osr_sel_e'(brg_osr);
        end
    end

    logic w_wrap;

    uart_baud_prescaler #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_prescaler (
        .i_clk     (pclk),
        .i_rst     (prst),
        .i_en      (brg_en),
        .i_div     (r_div),
        .i_frac    (r_frac),
        .o_wrap    (w_wrap),
        .o_os_tick (brg_os_tick)
    );

    logic [4:0] w_len;
    logic [3:0] w_last;
    logic [3:0] w_mid;

    assign w_len  = osr_len(r_osr);
    assign w_last = 4'(w_len - 5'd1);
    assign w_mid  = 4'((w_len >> 1) - 5'd1);

    logic [3:0] r_tx_os;
    logic [3:0] r_rx_os;
    logic       r_tx_tick;
    logic       r_rx_tick;
    logic       r_rx_sample;

    // A resync on a wrap edge swallows that os tick for the RX side only.
    always_ff @(posedge pclk) begin
        if (prst || !brg_en) begin
            r_tx_os     <= '0;
            r_rx_os     <= '0;
            r_tx_tick   <= 1'b0;
            r_rx_tick   <= 1'b0;
            r_rx_sample <= 1'b0;
        end else begin
            r_tx_tick   <= w_wrap && (r_tx_os == w_last);
            r_rx_tick   <= w_wrap && !rx_resync && (r_rx_os == w_last);
            r_rx_sample <= w_wrap && !rx_resync && (r_rx_os == w_mid);
            if (w_wrap) begin
                r_tx_os <= (r_tx_os == w_last) ? 4'd0 : r_tx_os + 4'd1;
            end
            if (rx_resync) begin
                r_rx_os <= 4'd0;
            end else if (w_wrap) begin
                r_rx_os <= (r_rx_os == w_last) ? 4'd0 : r_rx_os + 4'd1;
            end
        end
    end

    assign brg_tx_tick   = r_tx_tick;
    assign brg_rx_tick   = r_rx_tick;
    assign brg_rx_sample = r_rx_sample;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: expected tick edges are queued per
// stream when stimulus is applied and matched every cycle against the outputs.
module tb_uart_baud_gen;

    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;
    localparam int FRAC_SCALE = 1 << FRAC_W;
`ifdef UART_BAUD_FRAC_EN
    localparam int SPAN17 = 88;
`else
    localparam int SPAN17 = 80;
`endif

    logic              pclk = 1'b0;
    logic              prst;
    logic              brg_en;
    logic [DIV_W-1:0]  brg_div;
    logic [FRAC_W-1:0] brg_frac;
    logic [1:0]        brg_osr;
    logic              rx_resync;
    logic              brg_os_tick;
    logic              brg_tx_tick;
    logic              brg_rx_tick;
    logic              brg_rx_sample;

    uart_baud_gen #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) dut (
        .pclk          (pclk),
        .prst          (prst),
        .brg_en        (brg_en),
        .brg_div       (brg_div),
        .brg_frac      (brg_frac),
        .brg_osr       (brg_osr),
        .rx_resync     (rx_resync),
        .brg_os_tick   (brg_os_tick),
        .brg_tx_tick   (brg_tx_tick),
        .brg_rx_tick   (brg_rx_tick),
        .brg_rx_sample (brg_rx_sample)
    );

    // ---------------- clock / edge counter ----------------
    always #5 pclk = ~pclk;

    int edge_n = 0;
    always @(posedge pclk) edge_n <= edge_n + 1;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic mon_on = 1'b0;

    logic [31:0] os_q[$];
    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    logic [31:0] smp_q[$];
    logic [31:0] os_seen[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // ---------------- monitor ----------------
    logic exp_os, exp_tx, exp_rx, exp_smp;

    always @(negedge pclk) begin
        if (mon_on) begin
            exp_os  = (os_q.size()  > 0) && (os_q[0]  == edge_n);
            exp_tx  = (tx_q.size()  > 0) && (tx_q[0]  == edge_n);
            exp_rx  = (rx_q.size()  > 0) && (rx_q[0]  == edge_n);
            exp_smp = (smp_q.size() > 0) && (smp_q[0] == edge_n);
            if (exp_os)  void'(os_q.pop_front());
            if (exp_tx)  void'(tx_q.pop_front());
            if (exp_rx)  void'(rx_q.pop_front());
            if (exp_smp) void'(smp_q.pop_front());
            check("os_tick",   32'(brg_os_tick),   32'(exp_os));
            check("tx_tick",   32'(brg_tx_tick),   32'(exp_tx));
            check("rx_tick",   32'(brg_rx_tick),   32'(exp_rx));
            check("rx_sample", 32'(brg_rx_sample), 32'(exp_smp));
            if (brg_os_tick === 1'b1) os_seen.push_back(edge_n);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    // Expected tick edges for one enabled window starting after edge 'base'.
    // r1/r2 are relative resync edges (0 = none).
    task automatic push_expect(input int base, input int d, input int f, input int sel,
                               input int len, input int r1, input int r2);
        int e, acc, st, rxc, prev, osr;
        e = 0; acc = 0; st = 0; rxc = 0; prev = 0;
        osr = (sel == 1) ? 8 : (sel == 2) ? 4 : 16;
        for (int m = 1; m < 100000; m++) begin
            e = e + d + 1 + st;
`ifdef UART_BAUD_FRAC_EN
            st  = ((acc + f) >= FRAC_SCALE) ? 1 : 0;
            acc = (acc + f) % FRAC_SCALE;
`else
            st = (f < 0) ? 1 : 0;
`endif
            if (e > len) break;
            os_q.push_back(base + e);
            if (m % osr == 0) tx_q.push_back(base + e);
            if ((r1 > prev && r1 < e) || (r2 > prev && r2 < e)) rxc = 0;
            if (e == r1 || e == r2) begin
                rxc = 0;
            end else begin
                if (rxc == osr/2 - 1) smp_q.push_back(base + e);
                if (rxc == osr - 1)   rx_q.push_back(base + e);
                rxc = (rxc + 1) % osr;
            end
            prev = e;
        end
    endtask

    task automatic drive(input int len, input int r1, input int r2, input int mid_div);
        for (int k = 1; k <= len; k++) begin
            rx_resync = (k == r1) || (k == r2);
            if (k == len/2 && mid_div >= 0) brg_div = mid_div[DIV_W-1:0];
            step(1);
        end
        rx_resync = 1'b0;
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_os_left"},  os_q.size(),  0);
        check({tag, "_tx_left"},  tx_q.size(),  0);
        check({tag, "_rx_left"},  rx_q.size(),  0);
        check({tag, "_smp_left"}, smp_q.size(), 0);
    endtask

    task automatic run_case(input string tag, input int d, input int f, input int sel,
                            input int len, input int r1, input int r2, input int mid_div);
        int base;
        brg_en   = 1'b0;
        brg_div  = d[DIV_W-1:0];
        brg_frac = f[FRAC_W-1:0];
        brg_osr  = sel[1:0];
        step(1);
        os_seen.delete();
        base   = edge_n;
        brg_en = 1'b1;
        push_expect(base, d, f, sel, len, r1, r2);
        drive(len, r1, r2, mid_div);
        brg_en = 1'b0;
        step(3);
        check_drained(tag);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base;
        prst      = 1'b1;
        brg_en    = 1'b0;
        brg_div   = '0;
        brg_frac  = '0;
        brg_osr   = 2'd0;
        rx_resync = 1'b0;
        step(1);
        mon_on = 1'b1;
        step(2);
        check("reset_os",  32'(brg_os_tick),   0);
        check("reset_tx",  32'(brg_tx_tick),   0);
        check("reset_rx",  32'(brg_rx_tick),   0);
        check("reset_smp", 32'(brg_rx_sample), 0);
        prst = 1'b0;
        step(1);

        // div=3, 16x: os every 4, first bit tick after E63
        run_case("div3_osr16", 3, 0, 0, 200, 0, 0, -1);
        // divisor changed while enabled is ignored, then taken on re-enable
        run_case("div_live_chg", 3, 0, 0, 60, 0, 0, 7);
        run_case("div7_osr16", 7, 0, 0, 140, 0, 0, -1);
        run_case("div2_osr8", 2, 0, 1, 100, 0, 0, -1);
        run_case("div0_osr4", 0, 0, 2, 40, 0, 0, -1);
        run_case("div1_osr_rsvd", 1, 0, 3, 80, 0, 0, -1);

        // fractional divisor (ignored when the feature is not built)
        run_case("frac8", 4, 8, 0, 100, 0, 0, -1);
        if (os_seen.size() >= 17) check("frac_span17", os_seen[16] - os_seen[0], SPAN17);
        else                      check("frac_tick_count", os_seen.size(), 17);
        run_case("frac4_osr4", 2, 4, 2, 60, 0, 0, -1);

        // resync mid-bit (edge 21) and on the rx bit-end os tick (edge 52)
        run_case("resync", 1, 0, 1, 120, 21, 52, -1);

        // reset mid-bit with div=0, osr=4
        brg_en  = 1'b0;
        brg_div = '0;
        brg_osr = 2'd2;
        step(1);
        base   = edge_n;
        brg_en = 1'b1;
        push_expect(base, 0, 0, 2, 6, 0, 0);
        drive(6, 0, 0, -1);
        prst = 1'b1;
        step(1);
        check("midrst_os",  32'(brg_os_tick),   0);
        check("midrst_tx",  32'(brg_tx_tick),   0);
        check("midrst_rx",  32'(brg_rx_tick),   0);
        check("midrst_smp", 32'(brg_rx_sample), 0);
        prst = 1'b0;
        base = edge_n;
        push_expect(base, 0, 0, 0, 40, 0, 0);
        drive(40, 0, 0, -1);
        brg_en = 1'b0;
        step(1);
        base   = edge_n;
        brg_en = 1'b1;
        push_expect(base, 0, 0, 2, 20, 0, 0);
        drive(20, 0, 0, -1);
        brg_en = 1'b0;
        step(3);
        check_drained("reset_case");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_baud_gen.md
# uart_baud_gen

Parametrised UART baud-rate generator that supersedes the fixed 8-bit divider. It divides `pclk` by a programmable integer divisor with an optional fractional part, producing an oversample tick. Selectable oversampling ratios (16/8/4) derive independent TX bit ticks and RX bit/sample ticks from that oversample tick. It sits between the UART APB register file and the TX/RX shifters. The RX phase can be realigned to a detected start bit without disturbing TX.

## Interface
Parameters:
- `DIV_W`, 16, integer divisor width
- `FRAC_W`, 4, fractional divisor width (used only with `UART_BAUD_FRAC_EN`)

Ports:
- `pclk`  in  1  clock, all logic on rising edge
- `prst`  in  1  synchronous, active-high reset
- `brg_en`  in  1  generator enable; low clears counters and loads shadow config
- `brg_div`  in  DIV_W  integer divisor; oversample period = div+1 cycles
- `brg_frac`  in  FRAC_W  fractional divisor, units of 1/2^FRAC_W cycle
- `brg_osr`  in  2  oversample select: 0=16, 1=8, 2=4, 3=reserved (treated as 16)
- `rx_resync`  in  1  one-cycle pulse from RX start-bit detector; restarts RX phase
- `brg_os_tick`  out  1  oversample tick, one cycle wide
- `brg_tx_tick`  out  1  TX bit tick
- `brg_rx_tick`  out  1  RX bit-end tick
- `brg_rx_sample`  out  1  RX mid-bit sample tick

## Operation
- **Shadow config:** `brg_div`, `brg_frac` and `brg_osr` load into shadow registers every cycle that `brg_en`=0. They are frozen while `brg_en`=1. Changes made while enabled have no effect until the generator is disabled and re-enabled.
- **Prescaler:**
  - The counter is DIV_W+1 bits and is held at 0 while disabled.
  - Edge E0 is the first edge at which `brg_en` is sampled high.
  - The counter counts E0, E1, and so on. It wraps when it reaches `lim` = div + stretch.
  - On wrap, `brg_os_tick` is registered high for one cycle.
- **Fractional part (`UART_BAUD_FRAC_EN`):**
  - On each wrap, sum = acc + frac, computed FRAC_W+1 bits wide.
  - acc takes the low FRAC_W bits of sum.
  - The carry sets stretch=1 for the next period only, giving a period of div+2.
  - The average period is div+1+frac/2^FRAC_W.
- **TX path:**
  - A 4-bit `tx_os` counter increments on each os tick and wraps at OSR-1.
  - `brg_tx_tick` is asserted coincident with the os tick on which `tx_os`==OSR-1.
- **RX path:** a 4-bit `rx_os` counter.
  - `brg_rx_sample` is asserted with the os tick where `rx_os`==OSR/2-1.
  - `brg_rx_tick` is asserted with the os tick where `rx_os`==OSR-1. The counter then wraps.
- **`rx_resync`:** clears `rx_os` to 0. If it coincides with an os tick, resync wins: the tick is not counted, and no `brg_rx_sample` or `brg_rx_tick` is produced for that tick. `tx_os`, the prescaler and acc are unaffected.
- **Disable:** `brg_en` low clears the prescaler, acc, `tx_os` and `rx_os` at the next edge. All ticks are 0 from the following cycle.

## Timing
- **Reset:** `prst` clears all counters and acc, and sets the shadow config to div=0, frac=0, osr=16. All outputs are 0 the cycle after the reset edge. Reset mid-operation aborts the current period with no partial tick.
- **Tick registration:** all outputs are registered, one cycle wide, and never asserted while disabled.
- **First os tick:** high in the cycle after edge E(div).
- **div=0, frac=0:** `brg_os_tick` is high continuously, every cycle.
- **First bit tick:** the first `brg_tx_tick` / `brg_rx_tick` is the OSR-th os tick after enable or resync. The first `brg_rx_sample` is the (OSR/2)-th.
- **Fractional stretch:** the stretch never applies to the first period after enable.
- **Tick coincidence:** `brg_tx_tick` and `brg_rx_tick` may coincide with each other and with `brg_os_tick`. They are always a subset of `brg_os_tick` cycles.

## Configuration
- **`UART_BAUD_FRAC_EN` defined:** the fractional accumulator and stretch logic are built.
- **`UART_BAUD_FRAC_EN` undefined:**
  - The `brg_frac` port remains but is ignored.
  - No acc is built, and stretch is tied to 0.
  - The period is exactly div+1 cycles.

## Structure
- **Package `uart_baud_pkg`:** OSR select encodings, OSR length function (sel→16/8/4), default `DIV_W` and `FRAC_W` constants.
- **Sub-module `uart_baud_prescaler`:** integer/fractional divider producing `brg_os_tick`, instantiated once.
- **Top level:** shadow config plus the TX/RX oversample counters.

## Test plan
- div=3, frac=0, osr=0, enable: `brg_os_tick` every 4 cycles (first after E3); first `brg_tx_tick` after E63, then every 64 cycles.
- FRAC_EN, FRAC_W=4, div=4, frac=8: os-tick intervals are 5,5,6,5,6,…; 17 consecutive ticks span 88 cycles.
- div=1, osr=1, `rx_resync` pulse mid-bit: `brg_rx_sample` on the 4th os tick (8 cycles) after resync, `brg_rx_tick` on the 8th; `brg_tx_tick` cadence unchanged.
- `rx_resync` in the same cycle as an os tick with `rx_os`=OSR-1: no `brg_rx_tick`; the next `brg_rx_tick` comes OSR os ticks later.
- Change `brg_div` 3→7 while enabled: period stays 4; after `brg_en` low for 1 cycle and high again, period becomes 8.
- `prst` asserted mid-bit with div=0, osr=2: all outputs 0 the next cycle; after release, `brg_tx_tick` every 16 cycles (reset config osr=16); after `brg_en` low for 1 cycle and high again, `brg_tx_tick` every 4 cycles.
